// File: rtl/uart_rx_fifo.sv
// UART receiver with a first-word-fall-through receive FIFO and sticky status flags.
// Latency: stop-bit sample to FIFO head visible is 1 clk; RX to decision is 2 clk (synchronizer).
// Backpressure: none on the serial side; a frame arriving while full without a same-cycle pop is dropped and flagged in overrun.
//
// Ports:
//   clk, reset        : single clock domain, synchronous active-high reset
//   RX                : asynchronous serial input, idle high
//   baud_k            : clk cycles per bit (minimum 4), latched while idle
//   par_mode          : 00/11 none, 01 even, 10 odd, latched while idle
//   rd_en / rd_data   : pop request / FIFO head {frame_err, parity_err, data}
//   empty, full, count: FIFO occupancy status
//   overrun / clr_ovr : sticky drop flag and its clear
//   INTERRUPT/INT_ACK : receive interrupt, set on accepted push, cleared by ack

module uart_rx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         RX,
    input  logic [15:0]                  baud_k,
    input  logic [1:0]                   par_mode,
    input  logic                         rd_en,
    output logic [DATA_BITS+1:0]         rd_data,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(FIFO_DEPTH):0]  count,
    output logic                         overrun,
    input  logic                         clr_ovr,
    output logic                         INTERRUPT,
    input  logic                         INT_ACK
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam int EW = DATA_BITS + 2;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizer (resets to the idle line level)
    // ------------------------------------------------------------------
    logic r_rx_meta;
    logic r_rx_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= RX;
            r_rx_s    <= r_rx_meta;
        end
    end

    // ------------------------------------------------------------------
    // Receiver datapath registers
    // ------------------------------------------------------------------
    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [15:0]            r_cnt;
    logic [15:0]            r_baud;
    logic [1:0]             r_par;
    logic [BW-1:0]          r_bit_idx;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_par_err;

    logic [15:0]            w_baud_eff;
    logic                   w_at_half;
    logic                   w_at_end;
    logic                   w_par_en;
    logic                   w_par_exp;
    logic                   w_cnt_clr;
    logic                   w_bit_take;
    logic                   w_par_take;
    logic                   w_push;
    logic [EW-1:0]          w_push_dat;

    assign w_baud_eff = (baud_k < 16'd4) ? 16'd4 : baud_k;

    // The start bit is sampled at its midpoint; the counter is then restarted,
    // so every later bit is sampled when the counter completes a full period,
    // which again lands mid-bit.
    assign w_at_half  = (r_cnt == (r_baud >> 1));
    assign w_at_end   = (r_cnt == (r_baud - 16'd1));

    // Parity enabled only for 01 (even) and 10 (odd).
    assign w_par_en   = r_par[0] ^ r_par[1];
    // Expected parity bit: XOR of data, inverted for odd mode.
    assign w_par_exp  = (^r_shift) ^ r_par[1];

    assign w_push_dat = {~r_rx_s, r_par_err, r_shift};

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_clr   = 1'b0;
        w_bit_take  = 1'b0;
        w_par_take  = 1'b0;
        w_push      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (!r_rx_s) begin
                    w_state_nxt = START;
                    w_cnt_clr   = 1'b1;
                end
            end
            START: begin
                if (w_at_half) begin
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = r_rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (w_at_end) begin
                    w_cnt_clr  = 1'b1;
                    w_bit_take = 1'b1;
                    if (r_bit_idx == LAST_BIT) begin
                        w_state_nxt = w_par_en ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (w_at_end) begin
                    w_cnt_clr   = 1'b1;
                    w_par_take  = 1'b1;
                    w_state_nxt = STOP;
                end
            end
            STOP: begin
                if (w_at_end) begin
                    w_cnt_clr   = 1'b1;
                    w_push      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Bit timing, configuration latch, shift register, parity check
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_baud    <= 16'd4;
            r_par     <= 2'b00;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_par_err <= 1'b0;
        end else begin
            if (r_state == IDLE || w_cnt_clr) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 16'd1;
            end

            // Configuration is frozen for the duration of a frame.
            if (r_state == IDLE) begin
                r_baud    <= w_baud_eff;
                r_par     <= par_mode;
                r_bit_idx <= '0;
                r_par_err <= 1'b0;
            end

            if (w_bit_take) begin
                r_shift   <= {r_rx_s, r_shift[DATA_BITS-1:1]};
                r_bit_idx <= r_bit_idx + 1'b1;
            end

            if (w_par_take) begin
                r_par_err <= r_rx_s ^ w_par_exp;
            end
        end
    end

    // ------------------------------------------------------------------
    // Receive FIFO (first-word fall-through)
    // ------------------------------------------------------------------
    logic [EW-1:0]  r_mem [FIFO_DEPTH];
    logic [AW-1:0]  r_wptr;
    logic [AW-1:0]  r_rptr;
    logic [CW-1:0]  r_count;
    logic           r_ovr;
    logic           r_int;

    logic           w_empty;
    logic           w_full;
    logic           w_pop;
    logic           w_accept;
    logic           w_drop;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == FULL_CNT);
    assign w_pop    = rd_en && !w_empty;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign w_accept = w_push && (!w_full || w_pop);
    assign w_drop   = w_push && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wptr] <= w_push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_accept) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_accept && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_accept) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Set has priority over clear for both sticky flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovr <= 1'b0;
            r_int <= 1'b0;
        end else begin
            if (w_drop) begin
                r_ovr <= 1'b1;
            end else if (clr_ovr) begin
                r_ovr <= 1'b0;
            end

            if (w_accept) begin
                r_int <= 1'b1;
            end else if (INT_ACK) begin
                r_int <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        rd_data = '0;
        if (!w_empty) begin
            rd_data = r_mem[r_rptr];
        end
    end

    assign empty     = w_empty;
    assign full      = w_full;
    assign count     = r_count;
    assign overrun   = r_ovr;
    assign INTERRUPT = r_int;

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DATA_BITS, default 8, meaning data bits per frame; legal range 5..8.
REQ-002 Parameter FIFO_DEPTH, default 16, meaning receive FIFO entries; power of two, 2..256.
REQ-003 Port clk  input  1  system clock; one clock domain, all logic on rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port RX  input  1  serial line, idle high, asynchronous to clk.
REQ-006 Port baud_k  input  16  clk cycles per bit; values below 4 are treated as 4.
REQ-007 Port par_mode  input  2  parity mode: 00 none, 01 even, 10 odd, 11 none.
REQ-008 Port rd_en  input  1  pop request for the FIFO head.
REQ-009 Port rd_data  output  DATA_BITS+2  FIFO head {frame_err, parity_err, data}; first-word fall-through.
REQ-010 Port empty  output  1  FIFO holds zero entries.
REQ-011 Port full  output  1  FIFO holds FIFO_DEPTH entries.
REQ-012 Port count  output  log2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-013 Port overrun  output  1  sticky flag: a frame was dropped because the FIFO was full.
REQ-014 Port clr_ovr  input  1  clears overrun.
REQ-015 Port INTERRUPT  output  1  receive interrupt.
REQ-016 Port INT_ACK  input  1  interrupt acknowledge.

Function
REQ-017 RX shall pass through a 2-flop synchronizer; all decisions use the synchronized value rx_s.
REQ-018 The FSM shall have states IDLE, START, DATA, PARITY and STOP.
REQ-019 In IDLE, rx_s=0 shall move the FSM to START and clear the bit counter.
REQ-020 The bit counter shall count 0..baud_k-1; the sample point is count = baud_k>>1.
REQ-021 START: at the sample point, rx_s=1 returns the FSM to IDLE (false start, nothing pushed); rx_s=0 moves it to DATA with the counter reset so each later sample falls mid-bit.
REQ-022 DATA: DATA_BITS samples are taken LSB first, one per baud_k cycles; after the last sample the FSM goes to PARITY if par_mode is 01/10, otherwise to STOP.
REQ-023 PARITY: the sampled bit is compared with the XOR of the data bits (even) or its inverse (odd); a mismatch sets parity_err for this frame.
REQ-024 When parity is disabled, parity_err shall be 0.
REQ-025 STOP: at the sample point, rx_s=0 sets frame_err; the frame is pushed and the FSM returns to IDLE on the same edge.
REQ-026 Because of REQ-025, a new start bit is detectable from the next cycle.
REQ-027 Push-to-visible latency shall be 1 cycle: empty deasserts and rd_data is valid on the edge after the stop-bit sample.
REQ-028 rd_en while empty=1 shall be ignored.
REQ-029 rd_en while empty=0 shall advance the head on that edge.
REQ-030 Push and pop in the same cycle shall leave count unchanged, and both shall take effect.
REQ-031 A push while full with no pop shall drop the frame and set overrun; a push while full with a simultaneous pop shall be accepted.
REQ-032 Read and write pointers shall wrap modulo FIFO_DEPTH; count distinguishes full from empty.
REQ-033 INTERRUPT shall be set on any accepted push and cleared by INT_ACK.
REQ-034 If INT_ACK coincides with a push, INTERRUPT shall remain 1.
REQ-035 overrun shall be cleared by clr_ovr; if clr_ovr coincides with a new overrun event, overrun shall remain 1.
REQ-036 par_mode and baud_k shall be sampled only in IDLE; changes mid-frame take effect on the next frame.

Reset
REQ-037 On reset the FSM shall enter IDLE, with counters and pointers at 0.
REQ-038 Output reset values: count=0, empty=1, full=0, overrun=0, INTERRUPT=0, rd_data=0.
REQ-039 Synchronizer flops shall reset to 1.
REQ-040 Reset asserted mid-frame shall discard the partial frame and all FIFO contents.

Verification
REQ-041 baud_k=109, par_mode=01; send data bits 1,1,0,0,1,0,0,1 (LSB first), parity 0, stop 1 -> rd_data={0,0,0x93}, INTERRUPT=1, count=1.
REQ-042 Same frame with par_mode=10 -> rd_data={0,1,0x93}; with par_mode=00 and no parity bit -> rd_data={0,0,0x93}.
REQ-043 Frame 0x55 with stop bit 0 -> frame_err=1, data 0x55; a 20-cycle low glitch on RX -> no push.
REQ-044 FIFO_DEPTH=4: send 5 frames with no reads -> full=1, count=4, overrun=1, first four bytes read in order; also push with simultaneous rd_en while full -> accepted, count stays 4.
REQ-045 Assert reset during DATA of a frame with 2 entries queued -> empty=1, count=0, INTERRUPT=0; the next full frame is received correctly.
REQ-046 INT_ACK on the same cycle as a push -> INTERRUPT stays 1; INT_ACK alone afterwards -> INTERRUPT=0.
